// File: rtl/eeprom_disp_feeder.sv
// ============================================================================
//  Module   : eeprom_disp_feeder
//  Purpose  : 16-entry byte FIFO that replays EEPROM bytes as "index.byte"
//             values to the six-digit 7-segment driver, one per dwell period.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module eeprom_disp_feeder #(
    parameter int          DEPTH   = 16,
    parameter int          ADDR_W  = 4,
    parameter logic [25:0] CNT_MAX = 26'd49_999_999
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    input  logic        start,
    output logic [19:0] data,
    output logic [5:0]  point,
    output logic        sign,
    output logic        seg_en,
    output logic        busy,
    output logic        empty,
    output logic        full,
    output logic        overflow
);

    localparam logic [1:0]      IDLE       = 2'd0;
    localparam logic [1:0]      LOAD       = 2'd1;
    localparam logic [1:0]      SHOW       = 2'd2;
    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   count_next;
    logic [25:0]       timer;
    logic [ADDR_W-1:0] idx;
    logic [19:0]       data_next;

    logic wr_accept;
    logic wr_drop;
    logic tick_done;
    logic pop;
    logic pass_begin;
    logic idx_inc;

    // full is the registered flag, so a drop is decided before any same-cycle pop
    assign wr_accept  = wr_en & ~full;
    assign wr_drop    = wr_en & full;
    assign tick_done  = (state == SHOW) && (timer == CNT_MAX);
    assign count_next = count + (ADDR_W+1)'(wr_accept) - (ADDR_W+1)'(pop);
    assign data_next  = 20'(idx) * 20'd1000 + 20'(mem[rd_ptr]);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start && !empty) state_next = LOAD;
            LOAD:    state_next = SHOW;
            SHOW:    if (tick_done) state_next = empty ? IDLE : LOAD;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pop        = 1'b0;
        pass_begin = 1'b0;
        idx_inc    = 1'b0;
        case (state)
            IDLE:    pass_begin = start && !empty;
            LOAD:    pop = 1'b1;
            SHOW:    idx_inc = tick_done;
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)       rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            empty <= (count_next == '0);
            full  <= (count_next == FULL_COUNT);
        end
    end

    // A dropped write wins over the clear on a pass start in the same cycle
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            overflow <= 1'b0;
        end else if (wr_drop) begin
            overflow <= 1'b1;
        end else if (pass_begin) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            timer <= '0;
            idx   <= '0;
        end else begin
            if (pop) begin
                timer <= '0;
            end else if (state == SHOW) begin
                timer <= tick_done ? 26'd0 : timer + 26'd1;
            end
            if (pass_begin) begin
                idx <= '0;
            end else if (idx_inc) begin
                idx <= idx + 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            data   <= '0;
            point  <= '0;
            sign   <= 1'b0;
            seg_en <= 1'b0;
        end else begin
            sign <= 1'b0;
            if (pop) begin
                data   <= data_next;
                point  <= 6'b001000;
                seg_en <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/eeprom_disp_feeder.md
Name: eeprom_disp_feeder

Overview:
Upstream feeder for the six-digit dynamic 7-segment driver. It buffers bytes read back from the I2C EEPROM in a 16-entry FIFO. On a start pulse it pops the bytes one at a time and presents each one as a decimal value on the driver's data/point/sign/seg_en inputs, holding each value for a fixed dwell time. Each value is shown as "index.byte", for example 3.171 for the fourth byte with value 171.

Parameters:
DEPTH, 16, FIFO entries; must be a power of 2.
ADDR_W, 4, log2(DEPTH); width of the pointers and of the display index.
CNT_MAX, 26'd49_999_999, dwell-timer terminal count; one value is shown for CNT_MAX+1 cycles (1 s at 50 MHz).

Ports:
sys_clk  in  1  system clock; all logic on its rising edge.
sys_rst  in  1  synchronous, active-high reset.
wr_en  in  1  write strobe from the I2C read path; one byte per asserted cycle.
wr_data  in  8  byte read from the EEPROM.
start  in  1  single-cycle pulse (debounced key) that begins a display pass.
data  out  20  binary value for the display driver: idx*1000 + byte.
point  out  6  decimal-point mask for the display driver.
sign  out  1  sign for the display driver; always 0.
seg_en  out  1  display enable for the display driver.
busy  out  1  1 whenever the FSM is not in IDLE.
empty  out  1  1 when count == 0.
full  out  1  1 when count == DEPTH.
overflow  out  1  sticky flag: a write was dropped because the FIFO was full.

Behaviour:
- Reset (sync, sys_rst=1): pointers=0, count=0, FSM=IDLE, timer=0, idx=0. Outputs: data=0, point=0, sign=0, seg_en=0, busy=0, empty=1, full=0, overflow=0. Reset mid-pass aborts immediately and discards all FIFO contents.
- FIFO:
  - Storage is mem[DEPTH] x 8; count is ADDR_W+1 bits wide; pointers wrap modulo DEPTH.
  - A write is accepted when wr_en=1 and full=0: mem[wr_ptr]<=wr_data and wr_ptr++.
  - A write with wr_en=1 and full=1 is dropped and sets overflow=1. This applies even if a pop happens in the same cycle; full is evaluated before the pop.
  - An accepted write and a pop in the same cycle leave count unchanged while both pointers advance.
  - empty and full are registered and are consistent with count after each edge.
- FSM states: IDLE, LOAD, SHOW.
  - IDLE: if start=1 and empty=0, go to LOAD, set idx<=0 and clear overflow. A start while empty is ignored: stay in IDLE, overflow unchanged.
  - LOAD (one cycle):
    - pop mem[rd_ptr], rd_ptr++, count--;
    - data <= idx*1000 + byte (max 15*1000+255 = 15255, fits in 20 bits);
    - point <= 6'b001000, putting the dot on the thousands digit;
    - seg_en <= 1, timer <= 0;
    - go to SHOW.
  - SHOW: timer++ each cycle. When timer == CNT_MAX, set timer<=0 and idx<=idx+1 (wrapping at DEPTH). Then go to LOAD if empty=0, otherwise go to IDLE.
  - start is ignored in LOAD and SHOW.
  - Writes are accepted in every state, so bytes written during a pass extend that pass.
- Latency and display holding:
  - start accepted at edge k puts the FSM in LOAD after edge k.
  - The new data, point and seg_en are visible after edge k+1.
  - Each subsequent value appears CNT_MAX+2 cycles after the previous one (CNT_MAX+1 in SHOW plus 1 in LOAD).
  - After a pass ends, seg_en stays 1 and data/point hold the last value until reset; in IDLE the display keeps showing the last entry.
- busy = (state != IDLE), registered with the state.
- sign is a constant 0, but it is a registered output.

Test Plan:
- Reset, then idle with no writes: data=0, point=0, seg_en=0, empty=1, busy=0; a start pulse while empty leaves busy=0.
- CNT_MAX=9. Write 8'd171, 8'd5, 8'd255, then pulse start:
  - data=171, point=6'b001000 and seg_en=1 appear 2 edges after start;
  - data=1005 appears 11 cycles later, then data=2255;
  - busy falls after the third dwell, data holds 2255, empty=1.
- Write 17 bytes (0..16) back-to-back with no start: full=1 after the 16th; the 17th is dropped and overflow=1. A following start clears overflow, and the pass shows idx 0..15, ending with data=15015.
- CNT_MAX=9, FIFO full. Pulse start and assert wr_en with 8'd99 exactly in the LOAD cycle: the write is dropped and overflow=1. A write of 8'd99 one cycle later is accepted and shown as the 17th value with data=0099 (idx wrapped to 0).
- Write one byte, start, then write 8'd42 during SHOW: the pass continues into LOAD and shows data=1042 instead of returning to IDLE.
- Assert sys_rst for one cycle mid-SHOW with 3 entries queued: the next cycle shows state IDLE, count=0, seg_en=0, data=0; a later start is ignored.
